// File: rtl/calib_pkg.sv
// ----------------------------------------------------------------------------
// calib_pkg : shared types and helpers for the calibration pattern generator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package calib_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STREAM = 3'd1,
      LATCH  = 3'd2,
      SHOW   = 3'd3,
      DONE   = 3'd4
   } calib_pattern_state_t;

   localparam int          ID_MAX_WIDTH  = 32;
   localparam logic [63:0] LED_OFF_COLOR = 64'd0;

   function automatic logic led_plane_bit(input logic [ID_MAX_WIDTH-1:0] id,
                                          input logic [4:0]              k);
      return id[k];
   endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// ----------------------------------------------------------------------------
// cycle_timer : clearable up-counter that flags COUNT-1 and holds there
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
   parameter int COUNT = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_terminal) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_terminal = (r_count == CNT_W'(COUNT - 1));

endmodule

`default_nettype wire

// File: rtl/calib_pattern_gen.sv
// ----------------------------------------------------------------------------
// calib_pattern_gen : streams binary-coded LED ID bit-planes to a strand driver
// Optional macro CALIB_INVERT_PASS_EN adds a complemented pass per plane.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module calib_pattern_gen
   import calib_pkg::*;
#(
   parameter int                     NUM_LEDS          = 50,
   parameter int                     LED_ADDRESS_WIDTH = 10,
   parameter int                     COLOR_WIDTH       = 24,
   parameter logic [COLOR_WIDTH-1:0] ON_COLOR          = COLOR_WIDTH'(24'hFFFFFF),
   parameter int                     LATCH_CYCLES      = 20000
) (
   input  logic                                 clk_pixel,
   input  logic                                 rst_n,
   input  logic                                 advance_in,
   input  logic                                 restart_in,
   output logic                                 strand_start_out,
   input  logic                                 next_led_request,
   output logic [COLOR_WIDTH-1:0]               led_color_out,
   output logic [$clog2(NUM_LEDS)-1:0]          led_index_out,
   output logic [$clog2(LED_ADDRESS_WIDTH)-1:0] bit_index_out,
   output logic                                 displayed_frame_valid,
   output logic                                 busy_out,
   output logic                                 done_out,
   output logic                                 inverted_phase_out
);

   localparam int LIDX_W = $clog2(NUM_LEDS);
   localparam int BIDX_W = $clog2(LED_ADDRESS_WIDTH);

   localparam logic [LIDX_W-1:0] c_LAST_LED  = LIDX_W'(NUM_LEDS - 1);
   localparam logic [BIDX_W-1:0] c_TOP_PLANE = BIDX_W'(LED_ADDRESS_WIDTH - 1);

   generate
      if ((NUM_LEDS > (2**LED_ADDRESS_WIDTH) - 1) || (LED_ADDRESS_WIDTH > ID_MAX_WIDTH)) begin : g_bad_cfg
         $error("calib_pattern_gen: NUM_LEDS must be <= 2**LED_ADDRESS_WIDTH-1");
      end
   endgenerate

   calib_pattern_state_t   r_state, w_state_nxt;
   logic [BIDX_W-1:0]      r_bit_index, w_bit_index_nxt;
   logic [LIDX_W-1:0]      r_led_index, w_led_index_nxt;
   logic                   r_start, w_start_nxt;
   logic                   w_phase;
   logic                   w_timer_done;
   logic [LED_ADDRESS_WIDTH-1:0] w_id;
   logic                   w_lit;

`ifdef CALIB_INVERT_PASS_EN
   logic r_phase, w_phase_nxt;

   always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

   assign w_phase = r_phase;
`else
   assign w_phase = 1'b0;
`endif

   // Counter held clear outside LATCH so every latch gap starts from zero.
   cycle_timer #(
      .COUNT (LATCH_CYCLES)
   ) u_latch_timer (
      .clk        (clk_pixel),
      .rst_n      (rst_n),
      .i_clear    ((r_state != LATCH) || restart_in),
      .i_enable   (r_state == LATCH),
      .o_terminal (w_timer_done)
   );

   always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_bit_index <= c_TOP_PLANE;
         r_led_index <= '0;
         r_start     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_index <= w_bit_index_nxt;
         r_led_index <= w_led_index_nxt;
         r_start     <= w_start_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_bit_index_nxt = r_bit_index;
      w_led_index_nxt = r_led_index;
      w_start_nxt     = 1'b0;
`ifdef CALIB_INVERT_PASS_EN
      w_phase_nxt     = r_phase;
`endif
      if (restart_in) begin
         w_state_nxt     = IDLE;
         w_bit_index_nxt = c_TOP_PLANE;
         w_led_index_nxt = '0;
`ifdef CALIB_INVERT_PASS_EN
         w_phase_nxt     = 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (advance_in) begin
                  w_state_nxt = STREAM;
                  w_start_nxt = 1'b1;
               end
            end
            STREAM: begin
               if (next_led_request) begin
                  if (r_led_index == c_LAST_LED) begin
                     w_state_nxt     = LATCH;
                     w_led_index_nxt = '0;
                  end else begin
                     w_led_index_nxt = r_led_index + LIDX_W'(1);
                  end
               end
            end
            LATCH: begin
               if (w_timer_done) begin
                  w_state_nxt = SHOW;
               end
            end
            SHOW: begin
               if (advance_in) begin
`ifdef CALIB_INVERT_PASS_EN
                  if (!r_phase) begin
                     w_state_nxt = STREAM;
                     w_start_nxt = 1'b1;
                     w_phase_nxt = 1'b1;
                  end else if (r_bit_index == '0) begin
                     w_state_nxt = DONE;
                     w_phase_nxt = 1'b0;
                  end else begin
                     w_state_nxt     = STREAM;
                     w_start_nxt     = 1'b1;
                     w_bit_index_nxt = r_bit_index - BIDX_W'(1);
                     w_phase_nxt     = 1'b0;
                  end
`else
                  if (r_bit_index == '0) begin
                     w_state_nxt = DONE;
                  end else begin
                     w_state_nxt     = STREAM;
                     w_start_nxt     = 1'b1;
                     w_bit_index_nxt = r_bit_index - BIDX_W'(1);
                  end
`endif
               end
            end
            DONE: begin
               w_state_nxt = DONE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign w_id  = LED_ADDRESS_WIDTH'(r_led_index) + LED_ADDRESS_WIDTH'(1);
   assign w_lit = led_plane_bit(ID_MAX_WIDTH'(w_id), 5'(r_bit_index)) ^ w_phase;

   always_comb begin
      led_color_out = COLOR_WIDTH'(LED_OFF_COLOR);
      if ((r_state == STREAM) && w_lit) begin
         led_color_out = ON_COLOR;
      end
      strand_start_out      = r_start;
      led_index_out         = r_led_index;
      bit_index_out         = r_bit_index;
      displayed_frame_valid = (r_state == SHOW);
      busy_out              = (r_state == STREAM) || (r_state == LATCH);
      done_out              = (r_state == DONE);
      inverted_phase_out    = w_phase;
   end

endmodule

`default_nettype wire

// File: tb/tb_calib_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_calib_pattern_gen : directed self-checking bench for calib_pattern_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_calib_pattern_gen;

   logic        clk_pixel;
   logic        rst_n;
   logic        advance_in;
   logic        restart_in;
   logic        next_led_request;
   logic        strand_start_out;
   logic [23:0] led_color_out;
   logic [2:0]  led_index_out;
   logic [1:0]  bit_index_out;
   logic        displayed_frame_valid;
   logic        busy_out;
   logic        done_out;
   logic        inverted_phase_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] t_norm [3][5];
   logic [23:0] t_inv  [3][5];

`ifdef CALIB_INVERT_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif

   calib_pattern_gen #(
      .NUM_LEDS          (5),
      .LED_ADDRESS_WIDTH (3),
      .COLOR_WIDTH       (24),
      .ON_COLOR          (24'hFFFFFF),
      .LATCH_CYCLES      (4)
   ) u_dut (
      .clk_pixel             (clk_pixel),
      .rst_n                 (rst_n),
      .advance_in            (advance_in),
      .restart_in            (restart_in),
      .strand_start_out      (strand_start_out),
      .next_led_request      (next_led_request),
      .led_color_out         (led_color_out),
      .led_index_out         (led_index_out),
      .bit_index_out         (bit_index_out),
      .displayed_frame_valid (displayed_frame_valid),
      .busy_out              (busy_out),
      .done_out              (done_out),
      .inverted_phase_out    (inverted_phase_out)
   );

   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   // Entered right after the edge that moved the DUT into STREAM.
   task automatic run_plane(input int p, input int ph, input bit adv_in_latch);
      check_eq("start_pulse", 32'(strand_start_out), 32'd1);
      check_eq("plane_bit", 32'(bit_index_out), 32'(p));
      check_eq("phase", 32'(inverted_phase_out), 32'(ph));
      check_eq("busy_stream", 32'(busy_out), 32'd1);
      check_eq("valid_stream", 32'(displayed_frame_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check_eq("led_index", 32'(led_index_out), 32'(i));
         check_eq("color", 32'(led_color_out), 32'(ph != 0 ? t_inv[p][i] : t_norm[p][i]));
         if (i == 1) check_eq("start_one_cycle", 32'(strand_start_out), 32'd0);
         next_led_request = 1'b1;
         tick();
         next_led_request = 1'b0;
      end
      check_eq("busy_latch", 32'(busy_out), 32'd1);
      check_eq("color_latch", 32'(led_color_out), 32'd0);
      check_eq("index_latch", 32'(led_index_out), 32'd0);
      for (int c = 1; c <= 4; c++) begin
         if (adv_in_latch && c == 1) advance_in = 1'b1;
         next_led_request = (c == 2);
         tick();
         advance_in       = 1'b0;
         next_led_request = 1'b0;
         check_eq(c < 4 ? "valid_early" : "valid_rise", 32'(displayed_frame_valid), 32'(c == 4));
      end
      check_eq("busy_show", 32'(busy_out), 32'd0);
      check_eq("plane_held", 32'(bit_index_out), 32'(p));
   endtask

   initial begin
      t_norm[2] = '{24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
      t_norm[1] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
      t_norm[0] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
      t_inv[2]  = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
      t_inv[1]  = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
      t_inv[0]  = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};

      rst_n            = 1'b0;
      advance_in       = 1'b0;
      restart_in       = 1'b0;
      next_led_request = 1'b0;
      tick();
      tick();
      check_eq("rst_bit", 32'(bit_index_out), 32'd2);
      check_eq("rst_valid", 32'(displayed_frame_valid), 32'd0);
      check_eq("rst_color", 32'(led_color_out), 32'd0);
      check_eq("rst_start", 32'(strand_start_out), 32'd0);
      check_eq("rst_busy", 32'(busy_out), 32'd0);
      check_eq("rst_done", 32'(done_out), 32'd0);
      check_eq("rst_index", 32'(led_index_out), 32'd0);
      check_eq("rst_phase", 32'(inverted_phase_out), 32'd0);
      rst_n = 1'b1;
      tick();

      next_led_request = 1'b1;
      tick();
      next_led_request = 1'b0;
      check_eq("idle_req_ignored", 32'(led_index_out), 32'd0);

      advance_in = 1'b1;
      tick();
      advance_in = 1'b0;
      for (int p = 2; p >= 0; p--) begin
         for (int ph = 0; ph < NPASS; ph++) begin
            if (!(p == 2 && ph == 0)) begin
               advance_in = 1'b1;
               tick();
               advance_in = 1'b0;
            end
            run_plane(p, ph, (p == 2 && ph == 0));
         end
      end

      advance_in = 1'b1;
      tick();
      advance_in = 1'b0;
      check_eq("done_flag", 32'(done_out), 32'd1);
      check_eq("done_no_start", 32'(strand_start_out), 32'd0);
      check_eq("done_valid", 32'(displayed_frame_valid), 32'd0);
      check_eq("done_bit", 32'(bit_index_out), 32'd0);
      advance_in = 1'b1;
      tick();
      advance_in = 1'b0;
      check_eq("done_adv_start", 32'(strand_start_out), 32'd0);
      check_eq("done_adv_busy", 32'(busy_out), 32'd0);
      tick();
      check_eq("done_hold", 32'(done_out), 32'd1);
      restart_in = 1'b1;
      tick();
      restart_in = 1'b0;
      check_eq("restart_done", 32'(done_out), 32'd0);
      check_eq("restart_bit", 32'(bit_index_out), 32'd2);
      check_eq("restart_busy", 32'(busy_out), 32'd0);

      // restart beats a simultaneous advance while showing a plane
      advance_in = 1'b1;
      tick();
      advance_in = 1'b0;
      run_plane(2, 0, 1'b0);
      advance_in = 1'b1;
      restart_in = 1'b1;
      tick();
      advance_in = 1'b0;
      restart_in = 1'b0;
      check_eq("prio_bit", 32'(bit_index_out), 32'd2);
      check_eq("prio_start", 32'(strand_start_out), 32'd0);
      check_eq("prio_valid", 32'(displayed_frame_valid), 32'd0);
      check_eq("prio_busy", 32'(busy_out), 32'd0);

      // restart mid-stream, with a simultaneous request
      advance_in = 1'b1;
      tick();
      advance_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         next_led_request = 1'b1;
         tick();
         next_led_request = 1'b0;
      end
      check_eq("abort_pre_index", 32'(led_index_out), 32'd2);
      restart_in       = 1'b1;
      next_led_request = 1'b1;
      tick();
      restart_in       = 1'b0;
      next_led_request = 1'b0;
      check_eq("abort_r_index", 32'(led_index_out), 32'd0);
      check_eq("abort_r_busy", 32'(busy_out), 32'd0);
      check_eq("abort_r_color", 32'(led_color_out), 32'd0);
      repeat (6) tick();
      check_eq("abort_r_valid", 32'(displayed_frame_valid), 32'd0);

      // reset mid-stream
      advance_in = 1'b1;
      tick();
      advance_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         next_led_request = 1'b1;
         tick();
         next_led_request = 1'b0;
      end
      rst_n            = 1'b0;
      next_led_request = 1'b1;
      tick();
      rst_n            = 1'b1;
      next_led_request = 1'b0;
      check_eq("abort_x_index", 32'(led_index_out), 32'd0);
      check_eq("abort_x_start", 32'(strand_start_out), 32'd0);
      check_eq("abort_x_busy", 32'(busy_out), 32'd0);
      check_eq("abort_x_bit", 32'(bit_index_out), 32'd2);
      repeat (6) tick();
      check_eq("abort_x_valid", 32'(displayed_frame_valid), 32'd0);
      check_eq("abort_x_start2", 32'(strand_start_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
